// File: rtl/sdram_chip_responder.sv
// sdram_chip_responder: pin-level single-chip SDRAM device model for controller loop-back.
// Tracks per-bank row state and timing, stores data in a byte-writable array, flags protocol violations.
module sdram_chip_responder #(
  parameter int MEM_AW   = 12,
  parameter int TRCD     = 2,
  parameter int TRP      = 2,
  parameter int TREF_MAX = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_ncs,
  input  logic        sd_nras,
  input  logic        sd_ncas,
  input  logic        sd_nwe,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_a,
  input  logic        sd_dqml,
  input  logic        sd_dqmh,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic [1:0]  sd_dq_oe,
  output logic        ready,
  output logic [12:0] mode_reg,
  output logic [15:0] ref_cnt,
  output logic [8:0]  err
);

  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;

  localparam logic [7:0] TRCD_C = 8'(TRCD);
  localparam logic [7:0] TRP_C  = 8'(TRP);

  localparam int          GW      = $clog2(TREF_MAX + 2) + 1;
  localparam logic [GW-1:0] GAP_LIM = GW'(TREF_MAX + 1);
  localparam bit          GAP_EN  = (TREF_MAX > 0);

  typedef enum logic [1:0] {
    WAIT_PRE = 2'd0,
    WAIT_LMR = 2'd1,
    READY    = 2'd2
  } init_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  init_state_t state_r, state_next_s;

  logic [3:0]  open_r;
  logic [12:0] row_r       [4];
  logic [7:0]  since_act_r [4];
  logic [7:0]  since_pre_r [4];

  logic        is_act_s, is_rd_s, is_wr_s, is_pre_s, is_ref_s, is_lmr_s;
  logic        ready_s, any_open_s, bank_open_s;
  logic        act_go_s, rd_go_s, wr_go_s, lmr_go_s, mode_bad_s;
  logic [MEM_AW-1:0] mem_addr_s;
  logic [GW-1:0] gap_r, gap_next_s;
  logic [8:0]  err_set_s;

  logic [15:0] mem_r [0:(1<<MEM_AW)-1];
  logic        cl3_r;
  logic        rd_v1_r, rd_c3_r, rd_v2_r;
  logic [15:0] rd_d1_r, rd_d2_r;

  // Command decode; a deselected chip and BURST_TERMINATE both behave as NOP.
  always_comb begin
    is_act_s = 1'b0;
    is_rd_s  = 1'b0;
    is_wr_s  = 1'b0;
    is_pre_s = 1'b0;
    is_ref_s = 1'b0;
    is_lmr_s = 1'b0;
    if (sd_ncs) begin
      is_act_s = 1'b0;
    end else begin
      case ({sd_nras, sd_ncas, sd_nwe})
        CMD_ACT: is_act_s = 1'b1;
        CMD_RD:  is_rd_s  = 1'b1;
        CMD_WR:  is_wr_s  = 1'b1;
        CMD_PRE: is_pre_s = 1'b1;
        CMD_REF: is_ref_s = 1'b1;
        CMD_LMR: is_lmr_s = 1'b1;
        default: is_act_s = 1'b0;
      endcase
    end
  end

  // Qualified command strobes and the aliased word address.
  always_comb begin
    ready_s     = (state_r == READY);
    any_open_s  = |open_r;
    bank_open_s = open_r[sd_ba];
    act_go_s    = is_act_s & ready_s;
    rd_go_s     = is_rd_s & ready_s & bank_open_s;
    wr_go_s     = is_wr_s & ready_s & bank_open_s;
    lmr_go_s    = is_lmr_s & ~any_open_s;
    mode_bad_s  = ((sd_a[6:4] != 3'd2) && (sd_a[6:4] != 3'd3)) || (sd_a[2:0] != 3'd0);
    mem_addr_s  = MEM_AW'({sd_ba, row_r[sd_ba], sd_a[8:0]});
  end

  // Refresh-gap counter next value; only runs once initialisation is complete.
  always_comb begin
    gap_next_s = gap_r;
    if (is_ref_s) begin
      gap_next_s = {GW{1'b0}};
    end else if (GAP_EN && ready_s && (gap_r != GAP_LIM)) begin
      gap_next_s = gap_r + GW'(1);
    end else begin
      gap_next_s = gap_r;
    end
  end

  // Violation detection for this cycle's command.
  always_comb begin
    err_set_s    = 9'd0;
    err_set_s[0] = (is_act_s | is_rd_s | is_wr_s) & ~ready_s;
    err_set_s[1] = (is_rd_s | is_wr_s) & ready_s & ~bank_open_s;
    err_set_s[2] = act_go_s & bank_open_s;
    err_set_s[3] = (rd_go_s | wr_go_s) & (since_act_r[sd_ba] < TRCD_C);
    err_set_s[4] = act_go_s & (since_pre_r[sd_ba] < TRP_C);
    err_set_s[5] = (is_ref_s | is_lmr_s) & any_open_s;
    err_set_s[6] = is_wr_s & (sd_dq_oe != 2'b00);
    err_set_s[7] = lmr_go_s & mode_bad_s;
    err_set_s[8] = GAP_EN && (gap_next_s == GAP_LIM) && (gap_r != GAP_LIM);
  end

  // Init sequencer next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      WAIT_PRE: begin
        if (is_pre_s && sd_a[10]) begin
          state_next_s = WAIT_LMR;
        end else begin
          state_next_s = WAIT_PRE;
        end
      end
      WAIT_LMR: begin
        if (lmr_go_s) begin
          state_next_s = READY;
        end else begin
          state_next_s = WAIT_LMR;
        end
      end
      READY:   state_next_s = READY;
      default: state_next_s = WAIT_PRE;
    endcase
  end

  // Init state register and registered ready flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= WAIT_PRE;
      ready   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready   <= (state_next_s == READY);
    end
  end

  // Per-bank row tracking and ACT/precharge timers (saturating, start expired).
  always_ff @(posedge clk) begin
    if (reset) begin
      open_r <= 4'b0000;
      for (int b = 0; b < 4; b++) begin
        row_r[b]       <= 13'd0;
        since_act_r[b] <= 8'hFF;
        since_pre_r[b] <= 8'hFF;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        since_act_r[b] <= sat_inc8(since_act_r[b]);
        since_pre_r[b] <= sat_inc8(since_pre_r[b]);
      end
      if (act_go_s) begin
        open_r[sd_ba]      <= 1'b1;
        row_r[sd_ba]       <= sd_a;
        since_act_r[sd_ba] <= 8'd1;
      end
      if ((rd_go_s || wr_go_s) && sd_a[10]) begin
        open_r[sd_ba]      <= 1'b0;
        since_pre_r[sd_ba] <= 8'd1;
      end
      // Precharging an already idle bank is legal and leaves its tRP timer alone.
      if (is_pre_s) begin
        for (int b = 0; b < 4; b++) begin
          if (open_r[b] && (sd_a[10] || (sd_ba == 2'(b)))) begin
            open_r[b]      <= 1'b0;
            since_pre_r[b] <= 8'd1;
          end
        end
      end
    end
  end

  // Mode register; unsupported CAS latencies fall back to CL=2.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg <= 13'd0;
      cl3_r    <= 1'b0;
    end else if (lmr_go_s) begin
      mode_reg <= sd_a;
      cl3_r    <= (sd_a[6:4] == 3'd3);
    end
  end

  // Refresh counting, gap tracking and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= 16'd0;
      gap_r   <= {GW{1'b0}};
      err     <= 9'd0;
    end else begin
      if (is_ref_s && (ref_cnt != 16'hFFFF)) begin
        ref_cnt <= ref_cnt + 16'd1;
      end
      gap_r <= gap_next_s;
      err   <= err | err_set_s;
    end
  end

  // Backing array and read-data pipeline; reads capture contents before this edge's write.
  always_ff @(posedge clk) begin
    if (wr_go_s) begin
      if (!sd_dqml) begin
        mem_r[mem_addr_s][7:0] <= sd_dq_in[7:0];
      end
      if (!sd_dqmh) begin
        mem_r[mem_addr_s][15:8] <= sd_dq_in[15:8];
      end
    end
    if (rd_go_s) begin
      rd_d1_r <= mem_r[mem_addr_s];
    end
    if (rd_v1_r && rd_c3_r) begin
      rd_d2_r <= rd_d1_r;
    end
  end

  // Read pipeline valids; each entry carries the latency in force when it was issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v1_r <= 1'b0;
      rd_c3_r <= 1'b0;
      rd_v2_r <= 1'b0;
    end else begin
      rd_v1_r <= rd_go_s;
      rd_c3_r <= cl3_r;
      rd_v2_r <= rd_v1_r & rd_c3_r;
    end
  end

  // Registered data bus drive, valid for exactly one cycle per read.
  always_ff @(posedge clk) begin
    if (reset) begin
      sd_dq_out <= 16'd0;
      sd_dq_oe  <= 2'b00;
    end else if (rd_v1_r && !rd_c3_r) begin
      sd_dq_out <= rd_d1_r;
      sd_dq_oe  <= 2'b11;
    end else if (rd_v2_r) begin
      sd_dq_out <= rd_d2_r;
      sd_dq_oe  <= 2'b11;
    end else begin
      sd_dq_out <= 16'd0;
      sd_dq_oe  <= 2'b00;
    end
  end

endmodule

// File: tb/tb_sdram_chip_responder.sv
// tb_sdram_chip_responder: directed vectors against sdram_chip_responder with hand-computed expectations.
module tb_sdram_chip_responder;

  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sd_ncs = 1'b1;
  logic        sd_nras = 1'b1, sd_ncas = 1'b1, sd_nwe = 1'b1;
  logic [1:0]  sd_ba = 2'd0;
  logic [12:0] sd_a = 13'd0;
  logic        sd_dqml = 1'b1, sd_dqmh = 1'b1;
  logic [15:0] sd_dq_in = 16'd0;
  logic [15:0] sd_dq_out;
  logic [1:0]  sd_dq_oe;
  logic        ready;
  logic [12:0] mode_reg;
  logic [15:0] ref_cnt;
  logic [8:0]  err;

  int checks = 0;
  int errors = 0;

  sdram_chip_responder #(
    .MEM_AW(12), .TRCD(2), .TRP(2), .TREF_MAX(100)
  ) dut (
    .clk(clk), .reset(reset), .sd_ncs(sd_ncs), .sd_nras(sd_nras), .sd_ncas(sd_ncas),
    .sd_nwe(sd_nwe), .sd_ba(sd_ba), .sd_a(sd_a), .sd_dqml(sd_dqml), .sd_dqmh(sd_dqmh),
    .sd_dq_in(sd_dq_in), .sd_dq_out(sd_dq_out), .sd_dq_oe(sd_dq_oe), .ready(ready),
    .mode_reg(mode_reg), .ref_cnt(ref_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one command for exactly one rising edge, then return to NOP just after it.
  task automatic issue(input logic [2:0] cmd, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] dq, input logic [1:0] dqm_hl);
    @(negedge clk);
    sd_ncs = 1'b0;
    {sd_nras, sd_ncas, sd_nwe} = cmd;
    sd_ba = ba;
    sd_a = a;
    sd_dq_in = dq;
    {sd_dqmh, sd_dqml} = dqm_hl;
    @(posedge clk);
    #1;
    sd_ncs = 1'b1;
    {sd_nras, sd_ncas, sd_nwe} = C_NOP;
    {sd_dqmh, sd_dqml} = 2'b11;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_init();
    issue(C_PRE, 2'd0, 13'h0400, 16'h0000, 2'b11);
    issue(C_LMR, 2'd0, 13'h0020, 16'h0000, 2'b11);
  endtask

  initial begin
    // Reset state and basic init
    do_reset();
    check_val("rst_dq_out", sd_dq_out, 16'h0000);
    check_val("rst_dq_oe", sd_dq_oe, 2'b00);
    check_val("rst_ready", ready, 1'b0);
    check_val("rst_mode_reg", mode_reg, 13'h0000);
    check_val("rst_ref_cnt", ref_cnt, 16'h0000);
    check_val("rst_err", err, 9'h000);
    do_init();
    check_val("init_ready", ready, 1'b1);
    check_val("init_mode_reg", mode_reg, 13'h0020);
    check_val("init_err", err, 9'h000);

    // Full-word write with auto-precharge, then CL=2 readback
    issue(C_ACT, 2'd1, 13'd5, 16'h0000, 2'b11);
    tick(1);
    issue(C_WR, 2'd1, 13'h0403, 16'hA55A, 2'b00);
    tick(1);
    issue(C_ACT, 2'd1, 13'd5, 16'h0000, 2'b11);
    tick(1);
    issue(C_RD, 2'd1, 13'h0003, 16'h0000, 2'b11);
    check_val("cl2_oe_early", sd_dq_oe, 2'b00);
    tick(1);
    check_val("cl2_oe", sd_dq_oe, 2'b11);
    check_val("cl2_data", sd_dq_out, 16'hA55A);
    tick(1);
    check_val("cl2_oe_released", sd_dq_oe, 2'b00);
    check_val("wr_rd_err", err, 9'h000);

    // High byte masked write merges into the stored word
    issue(C_WR, 2'd1, 13'h0003, 16'h1234, 2'b10);
    issue(C_RD, 2'd1, 13'h0003, 16'h0000, 2'b11);
    tick(1);
    check_val("bytewr_oe", sd_dq_oe, 2'b11);
    check_val("bytewr_data", sd_dq_out, 16'hA534);
    tick(1);

    // CAS latency 3
    issue(C_PRE, 2'd0, 13'h0400, 16'h0000, 2'b11);
    issue(C_LMR, 2'd0, 13'h0030, 16'h0000, 2'b11);
    check_val("cl3_mode_reg", mode_reg, 13'h0030);
    issue(C_ACT, 2'd1, 13'd5, 16'h0000, 2'b11);
    tick(1);
    issue(C_RD, 2'd1, 13'h0003, 16'h0000, 2'b11);
    tick(1);
    check_val("cl3_oe_early", sd_dq_oe, 2'b00);
    tick(1);
    check_val("cl3_oe", sd_dq_oe, 2'b11);
    check_val("cl3_data", sd_dq_out, 16'hA534);
    tick(1);
    check_val("cl3_oe_released", sd_dq_oe, 2'b00);
    check_val("cl3_err", err, 9'h000);

    // Unsupported CAS latency
    issue(C_PRE, 2'd0, 13'h0400, 16'h0000, 2'b11);
    issue(C_LMR, 2'd0, 13'h0050, 16'h0000, 2'b11);
    check_val("badmode_mode_reg", mode_reg, 13'h0050);
    check_val("badmode_err", err, 9'h080);

    // Protocol violations accumulate sticky flags
    do_reset();
    check_val("rst2_err", err, 9'h000);
    issue(C_RD, 2'd0, 13'h0000, 16'h0000, 2'b11);
    check_val("early_rd_err", err, 9'h001);
    do_init();
    check_val("init2_ready", ready, 1'b1);
    issue(C_RD, 2'd2, 13'h0000, 16'h0000, 2'b11);
    check_val("idle_rd_err", err, 9'h003);
    tick(1);
    check_val("idle_rd_oe1", sd_dq_oe, 2'b00);
    tick(1);
    check_val("idle_rd_oe2", sd_dq_oe, 2'b00);
    issue(C_ACT, 2'd0, 13'd7, 16'h0000, 2'b11);
    issue(C_RD, 2'd0, 13'h0000, 16'h0000, 2'b11);
    check_val("trcd_err", err, 9'h00B);
    tick(1);
    check_val("trcd_rd_oe", sd_dq_oe, 2'b11);
    issue(C_WR, 2'd0, 13'h0000, 16'h0000, 2'b11);
    check_val("contention_err", err, 9'h04B);
    issue(C_ACT, 2'd0, 13'd7, 16'h0000, 2'b11);
    check_val("act_open_err", err, 9'h04F);
    issue(C_REF, 2'd0, 13'h0000, 16'h0000, 2'b11);
    check_val("ref_open_err", err, 9'h06F);
    check_val("ref_open_cnt", ref_cnt, 16'd1);
    issue(C_PRE, 2'd0, 13'h0000, 16'h0000, 2'b11);
    issue(C_ACT, 2'd0, 13'd7, 16'h0000, 2'b11);
    check_val("trp_err", err, 9'h07F);

    // Refresh gap limit and ref_cnt saturation
    do_reset();
    do_init();
    issue(C_REF, 2'd0, 13'h0000, 16'h0000, 2'b11);
    check_val("ref_cnt_one", ref_cnt, 16'd1);
    tick(100);
    check_val("gap_100_err", err, 9'h000);
    tick(1);
    check_val("gap_101_err", err, 9'h100);
    @(negedge clk);
    sd_ncs = 1'b0;
    {sd_nras, sd_ncas, sd_nwe} = C_REF;
    repeat (70000) @(posedge clk);
    #1;
    sd_ncs = 1'b1;
    {sd_nras, sd_ncas, sd_nwe} = C_NOP;
    check_val("ref_cnt_sat", ref_cnt, 16'hFFFF);
    check_val("ref_burst_err", err, 9'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
